window_fetch_ctrl: RTL and testbench
====================================

Name: window_fetch_ctrl

Overview:
Parametrised convolution-window fetcher for the feature-map RAM in the MobileNet datapath. It accepts a request carrying TAPS read addresses and latches them. It then issues one pipelined RAM read per cycle and assembles the returned words into a packed window. It holds that window under a valid/ready handshake until the MAC stage accepts it, and also offers a single-word quick-read path plus an independent write port.

Parameters:
DATA_W, 10, width of one RAM word / window element
ADDR_W, 12, RAM address width; depth = 2**ADDR_W
TAPS, 9, window elements per request (3x3 default)
RAM_LAT, 1, RAM read latency in cycles (1 or 2)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_wrEnable  in  1  write strobe
i_addrIn  in  ADDR_W  write address
i_data  in  DATA_W  write data
i_start  in  1  window request; accepted when i_start && o_ready
i_addrOut  in  TAPS*ADDR_W  tap k address at [k*ADDR_W +: ADDR_W]
o_ready  out  1  fetcher can accept a request
o_data  out  TAPS*DATA_W  window; tap k at [k*DATA_W +: DATA_W]
o_valid  out  1  o_data holds a complete window
i_outReady  in  1  consumer accepts window when o_valid && i_outReady
i_quickGet  in  1  single-word read request
i_addrOutQuick  in  ADDR_W  quick-read address
o_quickData  out  DATA_W  quick-read result
o_quickValid  out  1  one-cycle pulse, o_quickData valid

Behaviour:
- Clock and reset: single clock i_clk; i_reset is synchronous and active-high.
- Reset values: state IDLE; o_data=0, o_valid=0, o_quickValid=0, o_quickData=0. o_ready=0 while i_reset is high, then 1 from the first cycle after release. Reset mid-fetch or mid-hold abandons the operation, and in-flight read results are discarded.
- States:
  - IDLE: o_ready=1. On accept, latch all TAPS addresses, clear the tap counter, go to ISSUE. Later changes on i_addrOut are ignored.
  - ISSUE: one read per cycle for tap 0..TAPS-1 using the latched addresses. After tap TAPS-1, go to DRAIN.
  - DRAIN: wait RAM_LAT cycles for the last tap to return, then set o_valid=1 and go to HOLD.
  - HOLD: o_valid=1 and o_data stable until i_outReady. On handshake, o_valid clears next cycle and the state returns to IDLE. o_ready=0, so i_start is ignored.
- Tap capture: the tap index is delayed RAM_LAT stages alongside the read. The returning word is written only to its own slot; other slots hold.
- Latency: accept to o_valid is exactly TAPS+RAM_LAT cycles (10 with defaults).
- Quick read:
  - Accepted only in IDLE. i_start has priority; on simultaneous i_start and i_quickGet, the quick read is dropped.
  - o_quickValid pulses RAM_LAT cycles after the request and o_quickData is registered.
  - o_quickData holds its last value otherwise.
- Write port: always active, in every state.
- Read/write collision: read-during-write to the same address returns the old data (read-first).
- Tap counter width is clog2(TAPS). There is no wrap past TAPS-1.

Optional Feature:
WINDOW_ZERO_PAD_EN:
- Defined: a tap address equal to all-ones (2**ADDR_W-1) marks padding. No read is issued and the slot is forced to 0 at its normal return time, so latency is unchanged. The usable depth becomes 2**ADDR_W-1.
- Undefined: the all-ones address is read like any other address.

Decomposition:
- Shared package window_fetch_pkg:
  - state encoding (IDLE, ISSUE, DRAIN, HOLD)
  - localparams TAP_IDX_W=clog2(TAPS) and PAD_ADDR={ADDR_W{1'b1}}
- Sub-module conv_window_ram: simple dual-port RAM with parameters DATA_W, ADDR_W, RAM_LAT and read-first behaviour. The fetch controller muxes the fetch and quick addresses onto its single read port.

Test Plan:
- Reset, then write mem[a]=a+3 for a=0..15. Request taps 0..8 -> o_valid exactly 10 cycles after accept; slots 0..8 = 3..11.
- Backpressure: hold i_outReady=0 for 5 cycles after o_valid -> o_valid and o_data stable, o_ready=0, a pulsed i_start is ignored. After the handshake, o_ready=1 the next cycle.
- Request taps 0..8, then drive i_addrOut to all 15s the cycle after accept -> window still 3..11.
- Quick read in IDLE, addr 5 -> o_quickValid pulse RAM_LAT cycles later with data 8. Simultaneous i_start and i_quickGet -> fetch proceeds, no o_quickValid.
- Assert i_reset during ISSUE at tap 4 -> next cycle o_valid=0, o_data=0. After release o_ready=1 and no stray o_valid. Repeat with RAM_LAT=2.
- mem[4095]=0x3FF, tap 3 addr 4095 -> slot 3 = 0 with WINDOW_ZERO_PAD_EN, 0x3FF without. Write addr 2 with 0x155 in the same cycle tap 2 reads it -> slot 2 holds the old value 5.

Source files
------------

// File: rtl/window_fetch_pkg.sv
// Shared types and constants for the convolution-window fetcher.
// Purely declarative: no logic, no latency.
// Optional feature macro used by the controller: WINDOW_ZERO_PAD_EN.
package window_fetch_pkg;

  // Fetcher control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetchState_t;

  // Default geometry: 3x3 window over a 4K-word feature-map RAM.
  localparam int DEF_TAPS   = 9;
  localparam int DEF_ADDR_W = 12;

  // Tap counter width and padding marker for the default geometry.
  localparam int TAP_IDX_W = $clog2(DEF_TAPS);
  localparam logic [DEF_ADDR_W-1:0] PAD_ADDR = {DEF_ADDR_W{1'b1}};

  // Tap counter width for an arbitrary window size (at least one bit).
  function automatic int tapIdxWidth(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/conv_window_ram.sv
// Simple dual-port feature-map RAM: one write port, one read port.
// Read data appears RAM_LAT cycles after a read is issued; read-first on collision.
// No backpressure: write port always active, read port accepts every cycle.
module conv_window_ram #(
  parameter int DATA_W  = 10,
  parameter int ADDR_W  = 12,
  parameter int RAM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_wrEnable,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_rdEnable,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] mem     [2**ADDR_W];
  logic [DATA_W-1:0] rdStage [RAM_LAT];

  // Storage write, read-first array read, then the extra output stages.
  always_ff @(posedge i_clk) begin
    if (i_wrEnable) mem[i_wrAddr] <= i_wrData;
    if (i_rdEnable) rdStage[0] <= mem[i_rdAddr];
    for (int s = 1; s < RAM_LAT; s++) rdStage[s] <= rdStage[s-1];
  end

  assign o_rdData = rdStage[RAM_LAT-1];

endmodule

// File: rtl/window_fetch_ctrl.sv
// Window fetcher: latches TAPS addresses, reads one per cycle, presents a packed window.
// Latency: accept to o_valid is TAPS+RAM_LAT cycles; quick read returns RAM_LAT cycles later.
// Backpressure: window held until i_outReady; no new request while busy. Macro: WINDOW_ZERO_PAD_EN.
module window_fetch_ctrl
  import window_fetch_pkg::*;
#(
  parameter int DATA_W  = 10,
  parameter int ADDR_W  = 12,
  parameter int TAPS    = 9,
  parameter int RAM_LAT = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_wrEnable,
  input  logic [ADDR_W-1:0]      i_addrIn,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_start,
  input  logic [TAPS*ADDR_W-1:0] i_addrOut,
  output logic                   o_ready,
  output logic [TAPS*DATA_W-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_outReady,
  input  logic                   i_quickGet,
  input  logic [ADDR_W-1:0]      i_addrOutQuick,
  output logic [DATA_W-1:0]      o_quickData,
  output logic                   o_quickValid
);

  localparam int TIW = (TAPS == DEF_TAPS) ? TAP_IDX_W : tapIdxWidth(TAPS);
  localparam logic [TIW-1:0] LAST_TAP = TIW'(TAPS - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(RAM_LAT - 1);

  fetchState_t state, nextState;

  logic [TAPS-1:0][ADDR_W-1:0] tapAddr;
  logic [TIW-1:0]              tapCnt;
  logic [1:0]                  drainCnt;
  logic                        accept, quickAcc, issue, curPad, rdEn;
  logic [ADDR_W-1:0]           curAddr, rdAddr;
  logic [DATA_W-1:0]           ramRdData, quickHold;

  // Per-read tags travel alongside the RAM pipeline so each word lands in its own slot.
  logic [RAM_LAT-1:0]          tagVld, tagPad, quickTag;
  logic [RAM_LAT-1:0][TIW-1:0] tagIdx;
  logic [TAPS-1:0][DATA_W-1:0] window;

  assign o_ready  = (state == IDLE) && !i_reset;
  assign accept   = i_start && o_ready;
  // A simultaneous window request wins; the quick read is simply dropped.
  assign quickAcc = i_quickGet && !i_start && o_ready;
  assign issue    = (state == ISSUE);
  assign curAddr  = tapAddr[tapCnt];

`ifdef WINDOW_ZERO_PAD_EN
  localparam logic [ADDR_W-1:0] PAD = (ADDR_W == DEF_ADDR_W) ? ADDR_W'(PAD_ADDR) : {ADDR_W{1'b1}};
  assign curPad = (curAddr == PAD);
`else
  assign curPad = 1'b0;
`endif

  // Padding taps skip the RAM; the fetch port has priority over quick reads.
  assign rdEn   = (issue && !curPad) || quickAcc;
  assign rdAddr = issue ? curAddr : i_addrOutQuick;

  conv_window_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RAM_LAT(RAM_LAT)
  ) uRam (
    .i_clk     (i_clk),
    .i_wrEnable(i_wrEnable),
    .i_wrAddr  (i_addrIn),
    .i_wrData  (i_data),
    .i_rdEnable(rdEn),
    .i_rdAddr  (rdAddr),
    .o_rdData  (ramRdData)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = ISSUE;
      ISSUE:   if (tapCnt == LAST_TAP) nextState = DRAIN;
      DRAIN:   if (drainCnt == DRAIN_LAST) nextState = HOLD;
      HOLD:    if (i_outReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Address latch, tap counter (stops at the last tap) and drain counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tapAddr  <= '0;
      tapCnt   <= '0;
      drainCnt <= '0;
    end else begin
      if (accept) begin
        tapAddr <= i_addrOut;
        tapCnt  <= '0;
      end else if (issue && (tapCnt != LAST_TAP)) begin
        tapCnt <= tapCnt + 1'b1;
      end
      drainCnt <= (state == DRAIN) ? drainCnt + 2'd1 : 2'd0;
    end
  end

  // Tag pipeline matching the RAM read latency; reset drops in-flight reads.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tagVld   <= '0;
      tagPad   <= '0;
      tagIdx   <= '0;
      quickTag <= '0;
    end else begin
      tagVld[0]   <= issue;
      tagPad[0]   <= curPad;
      tagIdx[0]   <= tapCnt;
      quickTag[0] <= quickAcc;
      for (int s = 1; s < RAM_LAT; s++) begin
        tagVld[s]   <= tagVld[s-1];
        tagPad[s]   <= tagPad[s-1];
        tagIdx[s]   <= tagIdx[s-1];
        quickTag[s] <= quickTag[s-1];
      end
    end
  end

  // Capture returning words into their own slot; other slots hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      window <= '0;
    end else if (tagVld[RAM_LAT-1]) begin
      window[tagIdx[RAM_LAT-1]] <= tagPad[RAM_LAT-1] ? '0 : ramRdData;
    end
  end

  // Remember the last quick-read word so the output holds between pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset)                    quickHold <= '0;
    else if (quickTag[RAM_LAT-1])   quickHold <= ramRdData;
  end

  assign o_data       = window;
  assign o_valid      = (state == HOLD);
  assign o_quickValid = quickTag[RAM_LAT-1];
  assign o_quickData  = quickTag[RAM_LAT-1] ? ramRdData : quickHold;

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Bench for window_fetch_ctrl: reference memory model with read-first timing,
// randomized fetches and writes, scenario tasks with inline comparisons.
module tb_window_fetch_ctrl;
  parameter int RAM_LAT = 1;
  localparam int DATA_W = 10;
  localparam int ADDR_W = 12;
  localparam int TAPS   = 9;

  logic                   i_clk = 1'b0;
  logic                   i_reset, i_wrEnable, i_start, i_outReady, i_quickGet;
  logic [ADDR_W-1:0]      i_addrIn, i_addrOutQuick;
  logic [DATA_W-1:0]      i_data;
  logic [TAPS*ADDR_W-1:0] i_addrOut;
  logic                   o_ready, o_valid, o_quickValid;
  logic [TAPS*DATA_W-1:0] o_data;
  logic [DATA_W-1:0]      o_quickData;

  window_fetch_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAPS(TAPS), .RAM_LAT(RAM_LAT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wrEnable(i_wrEnable), .i_addrIn(i_addrIn),
    .i_data(i_data), .i_start(i_start), .i_addrOut(i_addrOut), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_outReady(i_outReady), .i_quickGet(i_quickGet),
    .i_addrOutQuick(i_addrOutQuick), .o_quickData(o_quickData), .o_quickValid(o_quickValid)
  );

  always #5 i_clk = ~i_clk;

  logic [DATA_W-1:0] model [0:(1<<ADDR_W)-1];
  int nRun = 0;
  int nFail = 0;

  // Expected word for one tap address given the current memory contents.
  function automatic logic [DATA_W-1:0] expTap(input logic [ADDR_W-1:0] a);
`ifdef WINDOW_ZERO_PAD_EN
    if (a == {ADDR_W{1'b1}}) return '0;
`endif
    return model[a];
  endfunction

  // One clock; a write driven before the edge lands in the model after it.
  task automatic step();
    logic w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    w = i_wrEnable; a = i_addrIn; d = i_data;
    @(posedge i_clk); #1;
    if (w) model[a] = d;
  endtask

  task automatic writeWord(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    i_wrEnable = 1'b1; i_addrIn = a; i_data = d;
    step();
    i_wrEnable = 1'b0;
  endtask

  // Drive one request and run until o_valid (bounded). wrMode: 0 none, 1 random, 2 write addr 2 during tap 2.
  // lat: cycles from accept to o_valid, -1 on timeout, -2 if o_valid rose during issue.
  task automatic runFetch(input logic [TAPS*ADDR_W-1:0] addrs, input int wrMode, input bit scramble,
                          input bit quickToo, output int lat, output logic [TAPS*DATA_W-1:0] expW,
                          output int quickSeen);
    logic [ADDR_W-1:0] a;
    bit early;
    early = 0; quickSeen = 0; lat = 0; expW = '0;
    i_addrOut = addrs; i_start = 1'b1; i_quickGet = quickToo; i_addrOutQuick = 12'd5;
    step();
    i_start = 1'b0; i_quickGet = 1'b0;
    i_addrOut = scramble ? {TAPS{12'd15}} : {TAPS{ADDR_W'($urandom_range(0, 15))}};
    for (int k = 0; k < TAPS; k++) begin
      a = addrs[k*ADDR_W +: ADDR_W];
      expW[k*DATA_W +: DATA_W] = expTap(a);
      i_wrEnable = 1'b0;
      if (wrMode == 1 && $urandom_range(0, 1) == 1) begin
        i_wrEnable = 1'b1; i_addrIn = ADDR_W'($urandom_range(0, 15)); i_data = DATA_W'($urandom);
      end
      if (wrMode == 2 && k == 2) begin
        i_wrEnable = 1'b1; i_addrIn = 12'd2; i_data = 10'h155;
      end
      if (o_quickValid) quickSeen++;
      if (o_valid) early = 1;
      step(); lat++;
    end
    i_wrEnable = 1'b0;
    while (!o_valid && lat < 40) begin
      if (o_quickValid) quickSeen++;
      step(); lat++;
    end
    if (!o_valid) lat = -1;
    if (early) lat = -2;
  endtask

  task automatic handshake();
    i_outReady = 1'b1;
    step();
    i_outReady = 1'b0;
  endtask

  function automatic logic [TAPS*ADDR_W-1:0] seqAddrs();
    logic [TAPS*ADDR_W-1:0] v;
    for (int k = 0; k < TAPS; k++) v[k*ADDR_W +: ADDR_W] = ADDR_W'(k);
    return v;
  endfunction

  task automatic test_reset();
    i_reset = 1'b1; i_wrEnable = 0; i_start = 0; i_outReady = 0; i_quickGet = 0;
    i_addrIn = '0; i_data = '0; i_addrOut = '0; i_addrOutQuick = '0;
    step(); step();
    nRun++; if (o_ready !== 1'b0) begin nFail++; $display("FAIL reset_ready got=%b want=0", o_ready); end
    nRun++; if (o_valid !== 1'b0 || o_data !== '0) begin nFail++; $display("FAIL reset_window got vld=%b data=%h want 0/0", o_valid, o_data); end
    nRun++; if (o_quickValid !== 1'b0 || o_quickData !== '0) begin nFail++; $display("FAIL reset_quick got vld=%b data=%h want 0/0", o_quickValid, o_quickData); end
    i_reset = 1'b0;
    step();
    nRun++; if (o_ready !== 1'b1) begin nFail++; $display("FAIL release_ready got=%b want=1", o_ready); end
    for (int a = 0; a < 16; a++) writeWord(ADDR_W'(a), DATA_W'(a + 3));
    writeWord({ADDR_W{1'b1}}, 10'h3FF);
  endtask

  task automatic test_basic();
    int lat, qs;
    logic [TAPS*DATA_W-1:0] expW, planW;
    runFetch(seqAddrs(), 0, 0, 0, lat, expW, qs);
    for (int k = 0; k < TAPS; k++) planW[k*DATA_W +: DATA_W] = DATA_W'(k + 3);
    nRun++; if (lat != TAPS + RAM_LAT) begin nFail++; $display("FAIL basic_latency got=%0d want=%0d", lat, TAPS + RAM_LAT); end
    nRun++; if (o_data !== expW || o_data !== planW) begin nFail++; $display("FAIL basic_window got=%h want=%h", o_data, planW); end
    handshake();
    nRun++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin nFail++; $display("FAIL basic_release got vld=%b rdy=%b want 0/1", o_valid, o_ready); end
  endtask

  task automatic test_backpressure();
    int lat, qs, stray;
    logic [TAPS*DATA_W-1:0] expW;
    runFetch(seqAddrs(), 0, 0, 0, lat, expW, qs);
    for (int c = 0; c < 5; c++) begin
      nRun++;
      if (o_valid !== 1'b1 || o_data !== expW || o_ready !== 1'b0) begin
        nFail++; $display("FAIL hold_cycle%0d got vld=%b rdy=%b data=%h want 1/0 %h", c, o_valid, o_ready, o_data, expW);
      end
      i_start = (c == 2); i_addrOut = {TAPS{12'd7}};
      step();
    end
    i_start = 1'b0;
    handshake();
    nRun++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin nFail++; $display("FAIL hold_release got rdy=%b vld=%b want 1/0", o_ready, o_valid); end
    stray = 0;
    for (int c = 0; c < 15; c++) begin if (o_valid) stray++; step(); end
    nRun++; if (stray != 0) begin nFail++; $display("FAIL hold_ignored_start got=%0d valid cycles want=0", stray); end
  endtask

  task automatic test_addr_change();
    int lat, qs;
    logic [TAPS*DATA_W-1:0] expW;
    runFetch(seqAddrs(), 0, 1, 0, lat, expW, qs);
    nRun++; if (lat != TAPS + RAM_LAT || o_data !== expW) begin nFail++; $display("FAIL addr_latch got lat=%0d data=%h want %0d %h", lat, o_data, TAPS + RAM_LAT, expW); end
    handshake();
  endtask

  task automatic test_quick();
    int lat, qs;
    logic [ADDR_W-1:0] qa;
    logic [TAPS*DATA_W-1:0] expW;
    for (int n = 0; n < 7; n++) begin
      qa = (n == 0) ? 12'd5 : ADDR_W'($urandom_range(0, 15));
      i_quickGet = 1'b1; i_addrOutQuick = qa;
      step();
      i_quickGet = 1'b0; i_addrOutQuick = ADDR_W'($urandom_range(0, 15));
      for (int c = 1; c < RAM_LAT; c++) begin
        nRun++; if (o_quickValid !== 1'b0) begin nFail++; $display("FAIL quick_early got=%b want=0", o_quickValid); end
        step();
      end
      nRun++; if (o_quickValid !== 1'b1 || o_quickData !== model[qa]) begin nFail++; $display("FAIL quick_read addr=%0d got vld=%b data=%h want 1/%h", qa, o_quickValid, o_quickData, model[qa]); end
      step();
      nRun++; if (o_quickValid !== 1'b0 || o_quickData !== model[qa]) begin nFail++; $display("FAIL quick_hold got vld=%b data=%h want 0/%h", o_quickValid, o_quickData, model[qa]); end
    end
    runFetch(seqAddrs(), 0, 0, 1, lat, expW, qs);
    nRun++; if (qs != 0 || lat != TAPS + RAM_LAT || o_data !== expW) begin nFail++; $display("FAIL quick_vs_start got pulses=%0d lat=%0d data=%h want 0 %0d %h", qs, lat, o_data, TAPS + RAM_LAT, expW); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int stray, lat, qs;
    logic [TAPS*DATA_W-1:0] expW;
    i_addrOut = seqAddrs(); i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 4; c++) step();
    i_reset = 1'b1;
    step();
    nRun++; if (o_valid !== 1'b0 || o_data !== '0 || o_ready !== 1'b0) begin nFail++; $display("FAIL midreset got vld=%b rdy=%b data=%h want 0/0/0", o_valid, o_ready, o_data); end
    i_reset = 1'b0;
    step();
    nRun++; if (o_ready !== 1'b1) begin nFail++; $display("FAIL midreset_ready got=%b want=1", o_ready); end
    stray = 0;
    for (int c = 0; c < 20; c++) begin if (o_valid || o_quickValid || o_data !== '0) stray++; step(); end
    nRun++; if (stray != 0) begin nFail++; $display("FAIL midreset_stray got=%0d bad cycles want=0", stray); end
    runFetch(seqAddrs(), 0, 0, 0, lat, expW, qs);
    nRun++; if (lat != TAPS + RAM_LAT || o_data !== expW) begin nFail++; $display("FAIL after_reset_fetch got lat=%0d data=%h want %0d %h", lat, o_data, TAPS + RAM_LAT, expW); end
    handshake();
  endtask

  task automatic test_pad_collision();
    int lat, qs;
    logic [TAPS*ADDR_W-1:0] addrs;
    logic [TAPS*DATA_W-1:0] expW;
    logic [DATA_W-1:0] want3;
    addrs = seqAddrs();
    addrs[3*ADDR_W +: ADDR_W] = {ADDR_W{1'b1}};
`ifdef WINDOW_ZERO_PAD_EN
    want3 = '0;
`else
    want3 = 10'h3FF;
`endif
    runFetch(addrs, 2, 0, 0, lat, expW, qs);
    nRun++; if (lat != TAPS + RAM_LAT || o_data !== expW) begin nFail++; $display("FAIL pad_window got lat=%0d data=%h want %0d %h", lat, o_data, TAPS + RAM_LAT, expW); end
    nRun++; if (o_data[3*DATA_W +: DATA_W] !== want3) begin nFail++; $display("FAIL pad_slot3 got=%h want=%h", o_data[3*DATA_W +: DATA_W], want3); end
    nRun++; if (o_data[2*DATA_W +: DATA_W] !== 10'd5) begin nFail++; $display("FAIL read_first_slot2 got=%h want=005", o_data[2*DATA_W +: DATA_W]); end
    handshake();
  endtask

  task automatic test_random();
    int lat, qs, wait_c;
    logic [TAPS*ADDR_W-1:0] addrs;
    logic [TAPS*DATA_W-1:0] expW;
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < TAPS; k++)
        addrs[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 7) == 0) ? {ADDR_W{1'b1}} : ADDR_W'($urandom_range(0, 15));
      runFetch(addrs, 1, 0, 0, lat, expW, qs);
      nRun++; if (lat != TAPS + RAM_LAT || o_data !== expW) begin nFail++; $display("FAIL random%0d got lat=%0d data=%h want %0d %h", n, lat, o_data, TAPS + RAM_LAT, expW); end
      wait_c = $urandom_range(0, 3);
      for (int c = 0; c < wait_c; c++) step();
      handshake();
      nRun++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin nFail++; $display("FAIL random%0d_release got vld=%b rdy=%b want 0/1", n, o_valid, o_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_addr_change();
    test_quick();
    test_pad_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
